// File: rtl/proc_pkg.sv
// Shared processor front-end types: default instruction/PC widths and the
// queue entry layout.
package proc_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } iq_entry_t;

endpackage

// File: rtl/iq_storage.sv
// Instruction queue storage: DEPTH x W array, one synchronous write port and
// one asynchronous read port. Contents are intentionally not reset.
module iq_storage #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue between fetch and decode, with flush on branch.
// Define IQ_BYPASS_EN to forward fetch straight to decode when the queue is empty.
module instr_prefetch_queue
  import proc_pkg::*;
#(
  parameter int IW    = INSTR_W,
  parameter int DEPTH = 4,
  parameter int AW    = PC_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [IW-1:0]          in_instr,
  input  logic [AW-1:0]          in_pc,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [IW-1:0]          out_instr,
  output logic [AW-1:0]          out_pc,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [IW+AW-1:0] rd_data;
  logic             stored_valid;
  logic             push, pop, do_push, do_pop, bypass_take;

  assign stored_valid = (count != '0);

`ifdef IQ_BYPASS_EN
  logic bypass_active;
  assign bypass_active = (count == '0) && in_valid && !flush;
  assign out_valid     = stored_valid || bypass_active;
  assign out_instr     = stored_valid  ? rd_data[IW+AW-1:AW] :
                         bypass_active ? in_instr : '0;
  assign out_pc        = stored_valid  ? rd_data[AW-1:0] :
                         bypass_active ? in_pc : '0;
  assign bypass_take   = bypass_active && out_ready;
`else
  assign out_valid   = stored_valid;
  assign out_instr   = stored_valid ? rd_data[IW+AW-1:AW] : '0;
  assign out_pc      = stored_valid ? rd_data[AW-1:0] : '0;
  assign bypass_take = 1'b0;
`endif

  assign in_ready = (count < CW'(DEPTH)) || (out_ready && out_valid);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  // A forwarded-and-consumed entry is a push and pop that cancel: never stored.
  assign do_push  = push && !bypass_take && !flush;
  assign do_pop   = pop && !bypass_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  iq_storage #(
    .DEPTH (DEPTH),
    .W     (IW + AW)
  ) u_storage (
    .clk   (clk),
    .we    (do_push),
    .waddr (wr_ptr),
    .wdata ({in_instr, in_pc}),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_instr_prefetch_queue;

  localparam int IW    = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 16;
`ifdef IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [IW-1:0] in_instr, out_instr;
  logic [AW-1:0] in_pc, out_pc;
  logic [2:0]    count;

  typedef struct {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
  } ent_t;

  ent_t q[$];
  int checks = 0;
  int errors = 0;

  instr_prefetch_queue #(.IW(IW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic bit m_byp();
    return BYP && (q.size() == 0) && in_valid && !flush;
  endfunction

  function automatic bit m_out_valid();
    return (q.size() > 0) || m_byp();
  endfunction

  function automatic bit m_in_ready();
    return (q.size() < DEPTH) || (out_ready && m_out_valid());
  endfunction

  task automatic drive(input bit v, input logic [IW-1:0] ins, input logic [AW-1:0] pc,
                       input bit ordy, input bit fl);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
  endtask

  // Advance one clock, updating the reference model from the pre-edge inputs.
  task automatic cycle();
    bit   take, pu, po, fl;
    ent_t e;
    take = m_byp() && out_ready;
    pu   = in_valid && m_in_ready();
    po   = m_out_valid() && out_ready;
    fl   = flush;
    e.instr = in_instr;
    e.pc    = in_pc;
    @(posedge clk);
    if (fl) q.delete();
    else if (!take) begin
      if (po) void'(q.pop_front());
      if (pu) q.push_back(e);
    end
    #1;
  endtask

  task automatic fill(input logic [IW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, base * IW'(i + 1), AW'(16'h0100 + i), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_instr !== '0 || out_pc !== '0) begin errors++; $display("FAIL reset_out_data: got %h/%h expected 0/0", out_instr, out_pc); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_reset_mid();
    fill(16'h0101, 3);
    #1;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL midreset_pre_count: got %0d expected 3", count); end
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL midreset_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b1, 16'h7777, 16'h0070, 1'b0, 1'b0);
    cycle();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    #1;
    checks++; if (count !== 3'd1 || out_instr !== 16'h7777) begin errors++; $display("FAIL midreset_first_push: got count %0d instr %h expected 1 7777", count, out_instr); end
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_fill();
    logic [IW-1:0] v [4];
    v = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, v[i], AW'(16'h0100 + i), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b1, 16'h9999, 16'h0999, 1'b0, 1'b0);
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_held_count: got %0d expected 4", count); end
    checks++; if (out_instr !== 16'h1111 || out_pc !== 16'h0100) begin errors++; $display("FAIL fill_head: got %h/%h expected 1111/0100", out_instr, out_pc); end
  endtask

  task automatic test_drain(input logic [IW-1:0] first);
    logic [IW-1:0] v [4];
    v = '{first, 16'h2222, 16'h3333, 16'h4444};
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_instr !== v[i]) begin errors++; $display("FAIL drain_%0d: got v=%b instr %h expected 1 %h", i, out_valid, out_instr, v[i]); end
      cycle();
    end
  endtask

  task automatic test_full_push_pop();
    fill(16'h1111, 4);
    drive(1'b1, 16'h5555, 16'h0555, 1'b1, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fullpp_in_ready: got %b expected 1", in_ready); end
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fullpp_count: got %0d expected 4", count); end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle();
    #1;
    checks++; if (out_instr !== 16'h5555 || out_pc !== 16'h0555) begin errors++; $display("FAIL fullpp_wrap: got %h/%h expected 5555/0555", out_instr, out_pc); end
    cycle();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fullpp_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    fill(16'h0A01, 3);
    drive(1'b1, 16'h6666, 16'h0666, 1'b0, 1'b1);
    #1;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
    cycle();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b0 || out_instr === 16'h6666) begin errors++; $display("FAIL flush_emit_%0d: got v=%b instr %h expected 0", i, out_valid, out_instr); end
      cycle();
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 16'hABCD, 16'h0040, 1'b1, 1'b0);
    #1;
`ifdef IQ_BYPASS_EN
    checks++; if (out_valid !== 1'b1 || out_instr !== 16'hABCD || out_pc !== 16'h0040) begin errors++; $display("FAIL bypass_same_cycle: got %b %h/%h expected 1 abcd/0040", out_valid, out_instr, out_pc); end
    cycle();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL bypass_count: got %0d expected 0", count); end
`else
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nobypass_same_cycle: got %b expected 0", out_valid); end
    cycle();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    #1;
    checks++; if (count !== 3'd1 || out_instr !== 16'hABCD || out_pc !== 16'h0040) begin errors++; $display("FAIL nobypass_next: got %0d %h/%h expected 1 abcd/0040", count, out_instr, out_pc); end
    cycle();
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL nobypass_drained: got %0d expected 0", count); end
`endif
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_random(input int n);
    logic [IW-1:0] ei;
    logic [AW-1:0] ep;
    for (int c = 0; c < n; c++) begin
      drive($urandom_range(0, 3) != 0, IW'($urandom), AW'($urandom),
            (c % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            $urandom_range(0, 39) == 0);
      #1;
      checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL rand_count@%0d: got %0d expected %0d", c, count, q.size()); end
      checks++; if (out_valid !== m_out_valid()) begin errors++; $display("FAIL rand_out_valid@%0d: got %b expected %b", c, out_valid, m_out_valid()); end
      checks++; if (in_ready !== m_in_ready()) begin errors++; $display("FAIL rand_in_ready@%0d: got %b expected %b", c, in_ready, m_in_ready()); end
      if (m_out_valid()) begin
        ei = (q.size() > 0) ? q[0].instr : in_instr;
        ep = (q.size() > 0) ? q[0].pc : in_pc;
        checks++; if (out_instr !== ei || out_pc !== ep) begin errors++; $display("FAIL rand_head@%0d: got %h/%h expected %h/%h", c, out_instr, out_pc, ei, ep); end
      end
      cycle();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain(16'h1111);
    test_full_push_pop();
    test_flush();
    test_bypass();
    test_reset_mid();
    test_random(600);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_prefetch_queue.md
INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 SHALL have parameter IW, default 16, instruction width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-003 SHALL have parameter AW, default 16, PC width tagged to each instruction.
REQ-004 SHALL use one clock; reset SHALL be asynchronous, active-low.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 flush  in  1  synchronous discard of all entries, e.g. on branch taken.
REQ-008 in_valid  in  1  fetch presents instruction.
REQ-009 in_instr  in  IW  fetched instruction word.
REQ-010 in_pc  in  AW  PC of in_instr.
REQ-011 in_ready  out  1  queue accepts this cycle.
REQ-012 out_valid  out  1  decode-side instruction available.
REQ-013 out_instr  out  IW  head instruction.
REQ-014 out_pc  out  AW  head PC.
REQ-015 out_ready  in  1  decode consumes head.
REQ-016 count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-017 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-018 Entries SHALL leave in FIFO order with instr/pc pairs never separated.
REQ-019 Without bypass, a pushed entry SHALL appear on out_* the cycle after the push (1-cycle latency).
REQ-020 in_ready SHALL be 1 when count < DEPTH, or count == DEPTH and out_ready && out_valid (pop frees a slot same cycle).
REQ-021 out_valid SHALL be 1 exactly when count > 0 (bypass excepted, REQ-031).
REQ-022 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-023 Read/write pointers SHALL wrap from DEPTH-1 to 0.
REQ-024 Push when full without simultaneous pop SHALL be blocked via in_ready=0; data SHALL NOT be overwritten.
REQ-025 out_instr/out_pc SHALL hold stable while out_valid && !out_ready.
REQ-026 flush SHALL set count=0 and pointers=0 next cycle; a push in the flush cycle SHALL be discarded; flush has priority over push and pop.
REQ-027 count SHALL equal pushes minus pops since last reset/flush, never exceeding DEPTH.

Reset
REQ-028 rst_n low SHALL immediately clear pointers and count; out_valid=0, in_ready=1, count=0.
REQ-029 out_instr/out_pc SHALL reset to 0; storage array contents SHALL not require reset.
REQ-030 Reset mid-operation SHALL discard all entries; first push after rst_n release behaves as from empty.

Configuration
REQ-031 With IQ_BYPASS_EN defined, when count==0 and in_valid, out_valid SHALL be 1 with out_* = in_* combinationally; if out_ready, the entry SHALL NOT be stored.
REQ-032 Without IQ_BYPASS_EN, no combinational path SHALL exist from in_* to out_*; latency is REQ-019.
REQ-033 flush SHALL suppress bypass out_valid in either build.

Structure
REQ-034 INSTR_W, PC_W defaults and the instr/pc entry struct typedef SHALL live in shared package proc_pkg.
REQ-035 Storage SHALL be sub-module iq_storage (DEPTH x (IW+AW), one write port, one async read port); pointer/count control stays in top.

Verification
REQ-036 Reset: rst_n=0 mid-stream with count=3 -> count=0, out_valid=0, in_ready=1 immediately.
REQ-037 Fill: push 0x1111,0x2222,0x3333,0x4444 with out_ready=0 -> count=4, in_ready=0; fifth push held, 0x1111 stays on out_instr.
REQ-038 Drain order: out_ready=1 after fill -> out_instr 0x1111,0x2222,0x3333,0x4444 on consecutive cycles, then out_valid=0.
REQ-039 Full push+pop: count=4, in_valid=1 (0x5555), out_ready=1 -> count stays 4, 0x5555 emerges after 0x4444, pointers wrap.
REQ-040 Flush: count=3, flush=1 with in_valid=1 (0x6666) -> next cycle count=0, out_valid=0, 0x6666 never emitted.
REQ-041 Bypass: IQ_BYPASS_EN, empty, in_valid=1 (0xABCD, pc 0x0040), out_ready=1 -> out_instr=0xABCD same cycle, count stays 0; without macro -> appears next cycle, count=1 then 0.
